// File: rtl/cas_pkg.sv
// Shared types and default timing for the cassette playback engine.
// The optional audio output is enabled with the CAS_AUDIO_EN macro (see cas_player).
package cas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_HI,
      ST_LO,
      ST_END
   } cas_state_t;

   // Half-cycle lengths at 57.27 MHz: 1200 Hz for a 0 bit, 2400 Hz for a 1 bit.
   localparam int unsigned CAS_HALF0_CNT = 23864;
   localparam int unsigned CAS_HALF1_CNT = 11932;

endpackage

// File: rtl/cas_player_if.sv
// Tape RAM read port between the playback engine (master) and the tape RAM (slave).
interface cas_player_if #(
   parameter int unsigned ADDR_W = 16
);
   // Handshake: mem_rd is a one-cycle strobe qualifying mem_addr; the RAM always
   // accepts (no ready) and mem_data is valid exactly one cycle after the strobe.
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_data;

   modport master (output mem_addr, output mem_rd, input mem_data);
   modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/cas_halfcnt.sv
// Loadable half-period down-counter; freezes while en=0 and flags terminal count.
module cas_halfcnt #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   input  logic             en,
   output logic             tc
);

   logic [DIV_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - DIV_W'(1);
      end
   end

   assign tc = en && (count == '0);

endmodule

// File: rtl/cas_player.sv
// Cassette playback engine: fetches tape bytes and emits them LSB-first as CoCo FSK.
// Define CAS_AUDIO_EN to add the signed audio_out sample port.
module cas_player
   import cas_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned HALF0_CNT = CAS_HALF0_CNT,
   parameter int unsigned HALF1_CNT = CAS_HALF1_CNT
`ifdef CAS_AUDIO_EN
   , parameter int unsigned AUDIO_W = 8
`endif
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      en,
   input  logic                      rewind,
   input  logic [ADDR_W:0]           tape_len,
   cas_player_if.master              mem,
   output logic                      data_out,
   output logic                      playing,
   output logic                      eot,
   output logic [ADDR_W:0]           byte_pos,
`ifdef CAS_AUDIO_EN
   output logic signed [AUDIO_W-1:0] audio_out,
`endif
   output cas_state_t                state_dbg
);

   localparam logic [ADDR_W:0] POS_MAX = {1'b1, {ADDR_W{1'b0}}};

   cas_state_t       state, state_n;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic             at_end;
   logic             mem_rd_c;
   logic             cnt_load, cnt_en, cnt_tc;
   logic [DIV_W-1:0] cnt_val;

   // Bit 7's low half is cut by 2 clocks so FETCH+WAIT keep the byte cadence exact.
   function automatic logic [DIV_W-1:0] half_load(input logic b, input logic last);
      int unsigned n;
      n = b ? HALF1_CNT : HALF0_CNT;
      return DIV_W'(last ? n - 3 : n - 1);
   endfunction

   assign at_end = (byte_pos >= tape_len);
   assign cnt_en = en && !rewind && ((state == ST_HI) || (state == ST_LO));

   cas_halfcnt #(.DIV_W(DIV_W)) u_halfcnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_n  = state;
      cnt_load = 1'b0;
      cnt_val  = '0;
      mem_rd_c = 1'b0;
      if (rewind) begin
         state_n = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:  if (en) state_n = ST_FETCH;
            ST_FETCH: begin
               if (at_end) begin
                  state_n = ST_END;
               end else begin
                  mem_rd_c = 1'b1;
                  state_n  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               state_n  = ST_HI;
               cnt_load = 1'b1;
               cnt_val  = half_load(mem.mem_data[0], 1'b0);
            end
            ST_HI: begin
               if (cnt_tc) begin
                  state_n  = ST_LO;
                  cnt_load = 1'b1;
                  cnt_val  = half_load(shreg[0], bit_idx == 3'd7);
               end
            end
            ST_LO: begin
               if (cnt_tc) begin
                  if (bit_idx != 3'd7) begin
                     state_n  = ST_HI;
                     cnt_load = 1'b1;
                     cnt_val  = half_load(shreg[1], 1'b0);
                  end else begin
                     state_n = ST_FETCH;
                  end
               end
            end
            ST_END:  state_n = ST_END;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         data_out <= 1'b0;
         eot      <= 1'b0;
         byte_pos <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         state    <= state_n;
         data_out <= (state_n == ST_HI);
         if (rewind) begin
            eot      <= 1'b0;
            byte_pos <= '0;
         end else begin
            case (state)
               ST_FETCH: if (at_end) eot <= 1'b1;
               ST_WAIT: begin
                  shreg   <= mem.mem_data;
                  bit_idx <= '0;
               end
               ST_LO: begin
                  if (cnt_tc) begin
                     if (bit_idx != 3'd7) begin
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= shreg >> 1;
                     end else if (byte_pos != POS_MAX) begin
                        byte_pos <= byte_pos + (ADDR_W+1)'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CAS_AUDIO_EN
   localparam logic signed [AUDIO_W-1:0] AUDIO_AMP = AUDIO_W'(2 ** (AUDIO_W - 2));

   // Silent whenever the motor is off, so a paused HI/LO reads as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         audio_out <= '0;
      end else if (!en || rewind) begin
         audio_out <= '0;
      end else if (state_n == ST_HI) begin
         audio_out <= AUDIO_AMP;
      end else if (state_n == ST_LO) begin
         audio_out <= -AUDIO_AMP;
      end else begin
         audio_out <= '0;
      end
   end
`endif

   assign mem.mem_rd   = mem_rd_c;
   assign mem.mem_addr = byte_pos[ADDR_W-1:0];
   assign playing      = en && ((state == ST_FETCH) || (state == ST_WAIT) ||
                                (state == ST_HI) || (state == ST_LO));
   assign state_dbg    = state;

endmodule

// File: tb/tb_cas_player.sv
// Bench for cas_player: random tapes replayed against an FSK waveform model built from the byte stream.
module tb_cas_player;
   import cas_pkg::*;

   localparam int ADDR_W = 4;
   localparam int DIV_W  = 8;
   localparam int H0     = 8;
   localparam int H1     = 4;
   localparam int AMP    = 64;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              en = 1'b0;
   logic              rewind = 1'b0;
   logic [ADDR_W:0]   tape_len = '0;
   logic              data_out, playing, eot;
   logic [ADDR_W:0]   byte_pos;
   cas_state_t        state_dbg;
`ifdef CAS_AUDIO_EN
   logic signed [7:0] audio_out;
`endif

   cas_player_if #(.ADDR_W(ADDR_W)) mem_bus ();

   cas_player #(
      .ADDR_W(ADDR_W), .DIV_W(DIV_W), .HALF0_CNT(H0), .HALF1_CNT(H1)
`ifdef CAS_AUDIO_EN
      , .AUDIO_W(8)
`endif
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .rewind    (rewind),
      .tape_len  (tape_len),
      .mem       (mem_bus),
      .data_out  (data_out),
      .playing   (playing),
      .eot       (eot),
      .byte_pos  (byte_pos),
`ifdef CAS_AUDIO_EN
      .audio_out (audio_out),
`endif
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- tape RAM model and read log ----------------
   logic [7:0]        ram [2**ADDR_W];
   logic [ADDR_W-1:0] rd_addr_q[$];

   always @(posedge clk) begin
      if (mem_bus.mem_rd) begin
         mem_bus.mem_data <= ram[mem_bus.mem_addr];
         rd_addr_q.push_back(mem_bus.mem_addr);
      end
   end

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   bit wave[$];
   int awave[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int half(input logic b);
      return b ? H1 : H0;
   endfunction

   function automatic int byte_cycles(input logic [7:0] v);
      int s = 0;
      for (int i = 0; i < 8; i++) s += 2 * half(v[i]);
      return s;
   endfunction

   // Ideal line waveform: 2 lead-in clocks, then per bit N high + N low.
   // The audio copy is silent during each 2-clock byte gap at the end of bit 7.
   task automatic build_wave(input int len);
      wave.delete();
      awave.delete();
      repeat (2) begin
         wave.push_back(1'b0);
         awave.push_back(0);
      end
      for (int b = 0; b < len; b++) begin
         for (int i = 0; i < 8; i++) begin
            int n = half(ram[b][i]);
            repeat (n) begin
               wave.push_back(1'b1);
               awave.push_back(AMP);
            end
            for (int j = 0; j < n; j++) begin
               wave.push_back(1'b0);
               awave.push_back((i == 7 && j >= n - 2) ? 0 : -AMP);
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic start(input int len);
      @(negedge clk);
      rewind = 1'b1;
      en     = 1'b0;
      @(negedge clk);
      rewind   = 1'b0;
      en       = 1'b1;
      tape_len = len[ADDR_W:0];
      rd_addr_q.delete();
   endtask

   // Plays a tape and compares every clock; the model pointer only advances on
   // clocks where the motor was on.
   task automatic play(input int len, input int eff_len, input int pause_at,
                       input int pause_len, input int shrink_at, input string tag);
      int ptr, lw, f0;
      start(len);
      build_wave(eff_len);
      lw  = wave.size();
      ptr = 0;
      f0  = fails;
      for (int k = 1; k <= lw + pause_len + 4; k++) begin
         @(negedge clk);
         if (k > 1 && en) ptr++;
         check({tag, "_data"}, data_out, (ptr < lw) ? wave[ptr] : 1'b0);
         check({tag, "_eot"}, eot, ptr >= lw - 1);
         check({tag, "_playing"}, playing, en && (ptr < lw - 1));
`ifdef CAS_AUDIO_EN
         check({tag, "_audio"}, 32'(audio_out), (en && ptr < lw) ? awave[ptr] : 0);
`endif
         if (fails != f0) break;
         if (k == pause_at) en = 1'b0;
         if (k == pause_at + pause_len) en = 1'b1;
         if (k == shrink_at) tape_len = eff_len[ADDR_W:0];
      end
      check({tag, "_byte_pos"}, byte_pos, eff_len);
      check({tag, "_rd_count"}, rd_addr_q.size(), eff_len);
      for (int i = 0; i < rd_addr_q.size(); i++)
         check({tag, "_rd_addr"}, rd_addr_q[i], i);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t0, n1, len;

      // Reset values while reset is held
      #1;
      check("rst_data", data_out, 1'b0);
      check("rst_playing", playing, 1'b0);
      check("rst_eot", eot, 1'b0);
      check("rst_byte_pos", byte_pos, 0);
      check("rst_mem_rd", mem_bus.mem_rd, 1'b0);
      check("rst_mem_addr", mem_bus.mem_addr, 0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_state", 32'(state_dbg), 32'(ST_IDLE));
      check("idle_mem_rd", mem_bus.mem_rd, 1'b0);

      // Single 8'hA5 byte
      ram[0] = 8'hA5;
      play(1, 1, 0, 0, 0, "a5");

      // Empty tape
      play(0, 0, 0, 0, 0, "empty");

      // Random short tapes
      for (int r = 0; r < 4; r++) begin
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) ram[i] = 8'($urandom_range(0, 255));
         play(len, len, 0, 0, 0, "rand");
      end

      // Full-length tape: byte_pos reaches 2^ADDR_W
      for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 8'($urandom_range(0, 255));
      play(2**ADDR_W, 2**ADDR_W, 0, 0, 0, "full");

      // Motor pause 3 clocks into the HI half of a 1 bit
      ram[0] = 8'($urandom_range(0, 255)) | 8'h01;
      ram[1] = 8'($urandom_range(0, 255));
      play(2, 2, 5, 20, 0, "pause");

      // Tape shortened during byte 0
      for (int i = 0; i < 3; i++) ram[i] = 8'($urandom_range(0, 255));
      play(3, 1, 0, 0, 20, "shrink");

      // Rewind in the middle of byte 1
      for (int i = 0; i < 3; i++) ram[i] = 8'($urandom_range(0, 255));
      t0 = byte_cycles(ram[0]);
      start(3);
      repeat (2 + t0 + 10) @(negedge clk);
      check("rw_pre_byte_pos", byte_pos, 1);
      rewind = 1'b1;
      @(negedge clk);
      check("rw_byte_pos", byte_pos, 0);
      check("rw_data", data_out, 1'b0);
      check("rw_mem_rd", mem_bus.mem_rd, 1'b0);
      check("rw_eot", eot, 1'b0);
      @(negedge clk);
      check("rw_hold_state", 32'(state_dbg), 32'(ST_IDLE));
      rewind = 1'b0;
      @(negedge clk);
      check("rw_restart_rd", mem_bus.mem_rd, 1'b1);
      check("rw_restart_addr", mem_bus.mem_addr, 0);

      // Asynchronous reset in the LO half of byte 1's first bit
      for (int i = 0; i < 2; i++) ram[i] = 8'($urandom_range(0, 255));
      t0 = byte_cycles(ram[0]);
      n1 = half(ram[1][0]);
      start(2);
      repeat (t0 + n1 + 4) @(negedge clk);
      check("ar_pre_data", data_out, 1'b0);
      check("ar_pre_byte_pos", byte_pos, 1);
      #2 reset_n = 1'b0;
      #1;
      check("ar_data", data_out, 1'b0);
      check("ar_byte_pos", byte_pos, 0);
      check("ar_eot", eot, 1'b0);
      check("ar_playing", playing, 1'b0);
      check("ar_mem_rd", mem_bus.mem_rd, 1'b0);
      check("ar_state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge clk);
      reset_n = 1'b1;

      // Playback after the abort starts again at byte 0
      play(2, 2, 0, 0, 0, "after_rst");

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
